// File: rtl/sel_encode_seq.sv
// Register-select encoder: IR fields to registered one-hot GRin/GRout strobes, either driven
// manually (Gra/Grb/Grc priority) or by an auto Rb/Rc-read, Ra-write sequence. Macro: SEL_R0_ZERO_EN.
module sel_encode_seq #(
    parameter int unsigned NREG   = 16,
    parameter int unsigned RW     = 4,
    parameter int unsigned RA_LSB = 23,
    parameter int unsigned RB_LSB = 19,
    parameter int unsigned RC_LSB = 15,
    parameter int unsigned C_W    = 19
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     ir_in,
    input  logic            ir_ld,
    input  logic            Gra,
    input  logic            Grb,
    input  logic            Grc,
    input  logic            Rin,
    input  logic            Rout,
    input  logic            BAout,
    input  logic            seq_start,
    output logic [31:0]     C,
    output logic [NREG-1:0] GRin,
    output logic [NREG-1:0] GRout,
    output logic            r0_zero,
    output logic            seq_busy,
    output logic            seq_done,
    output logic            sel_err
);

    typedef enum logic [2:0] {StIdle, StRdB, StRdC, StWrA, StDone} state_e;

    state_e          state_q, state_d;
    logic [31:0]     ir_q, ir_d;
    logic [NREG-1:0] grin_q, grin_d, grout_q, grout_d;
    logic            r0_zero_q, r0_zero_d, sel_err_q, sel_err_d;
    logic [RW-1:0]   ra_idx, rb_idx, rc_idx, sel_idx;
    logic            sel_any;
    logic            unused_ir;

    function automatic logic [NREG-1:0] dec(input logic [RW-1:0] idx);
        return {{(NREG-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Fields come from the IR as it stands after this edge, so a same-cycle load is seen.
    assign ir_d   = (ir_ld && state_q == StIdle) ? ir_in : ir_q;
    assign ra_idx = ir_d[RA_LSB +: RW];
    assign rb_idx = ir_d[RB_LSB +: RW];
    assign rc_idx = ir_d[RC_LSB +: RW];
    assign unused_ir = ^ir_d;

    always_comb begin
        sel_any = Gra | Grb | Grc;
        sel_idx = rc_idx;
        if (Gra) begin
            sel_idx = ra_idx;
        end else if (Grb) begin
            sel_idx = rb_idx;
        end
    end

    always_comb begin
        state_d   = state_q;
        grin_d    = '0;
        grout_d   = '0;
        r0_zero_d = 1'b0;
        sel_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (seq_start) begin
                    state_d = StRdB;
                    grout_d = dec(rb_idx);
                end else begin
                    sel_err_d = (Gra & Grb) | (Gra & Grc) | (Grb & Grc);
                    if (sel_any && Rin) grin_d = dec(sel_idx);
                    if (sel_any && (Rout || BAout)) grout_d = dec(sel_idx);
`ifdef SEL_R0_ZERO_EN
                    // Base-address read of R0 yields zero instead of the register.
                    if (sel_any && BAout && sel_idx == '0) begin
                        grout_d   = '0;
                        r0_zero_d = 1'b1;
                    end
`endif
                end
            end
            StRdB: begin
                state_d = StRdC;
                grout_d = dec(rc_idx);
            end
            StRdC: begin
                state_d = StWrA;
                grin_d  = dec(ra_idx);
            end
            StWrA:   state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            ir_q      <= '0;
            grin_q    <= '0;
            grout_q   <= '0;
            r0_zero_q <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            grin_q    <= grin_d;
            grout_q   <= grout_d;
            r0_zero_q <= r0_zero_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign C        = {{(32-C_W){ir_q[C_W-1]}}, ir_q[C_W-1:0]};
    assign GRin     = grin_q;
    assign GRout    = grout_q;
    assign r0_zero  = r0_zero_q;
    assign sel_err  = sel_err_q;
    assign seq_busy = (state_q != StIdle);
    assign seq_done = (state_q == StDone);

endmodule
